// File: rtl/ahb_slave_mem_responder.sv
// AHB-Lite slave responder: decodes the forwarded address phase, inserts WAIT_STATES
// wait cycles, serves a local byte-lane-writable memory, and returns two-cycle ERROR.
module ahb_smr_lane #(
  parameter int LANE   = 0,
  parameter int LANE_W = 2
) (
  input  logic [LANE_W-1:0] start,
  input  logic [2:0]        size,
  input  logic [7:0]        old_byte,
  input  logic [7:0]        new_byte,
  output logic [7:0]        merged
);
  logic hit;

  assign hit    = (LANE >= int'(start)) && (LANE < int'(start) + (1 << size));
  assign merged = hit ? new_byte : old_byte;
endmodule

module ahb_slave_mem_responder #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hselx,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);
  localparam int          NBYTES    = DATA_WIDTH / 8;
  localparam int          LANE_W    = $clog2(NBYTES);
  localparam int          IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'(NBYTES);
  localparam logic [3:0]  WS        = 4'(WAIT_STATES);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  typedef struct packed {
    logic              write;
    logic [2:0]        size;
    logic [LANE_W-1:0] lane;
    logic [IDX_W-1:0]  idx;
  } req_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  req_t                    req, req_nxt;
  logic                    accept, bad, load;
  logic [ADDR_WIDTH-1:0]   offset, align_mask;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
  logic [NBYTES-1:0][7:0]  old_w, new_w, merged_w;
  logic                    unused_bits;

  assign unused_bits = ^{htrans[0], hburst};

  // Address-phase decode; offset wraps when haddr < BASE_ADDR, caught explicitly too.
  assign accept     = hselx & hready & htrans[1];
  assign offset     = haddr - BASE_ADDR;
  assign align_mask = (ADDR_WIDTH'(1) << hsize) - ADDR_WIDTH'(1);
  assign bad        = (haddr < BASE_ADDR) || (64'(offset) >= MEM_BYTES) ||
                      (hsize > 3'(LANE_W)) || (|(haddr & align_mask));

  assign req_nxt.write = hwrite;
  assign req_nxt.size  = hsize;
  assign req_nxt.lane  = haddr[LANE_W-1:0];
  assign req_nxt.idx   = offset[LANE_W +: IDX_W];

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= S_IDLE;
      cnt   <= '0;
      req   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load) req <= req_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    case (state)
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = S_DATA;
      end
      S_ERR1: state_nxt = S_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all complete this cycle, so a new address may pipeline in.
        state_nxt = S_IDLE;
        if (accept) begin
          load = 1'b1;
          if (bad)            state_nxt = S_ERR1;
          else if (WS == '0)  state_nxt = S_DATA;
          else begin
            state_nxt = S_WAIT;
            cnt_nxt   = WS;
          end
        end
      end
    endcase
  end

  assign hreadyout = !((state == S_WAIT) || (state == S_ERR1));
  assign hresp     = (state == S_ERR1) || (state == S_ERR2);
  assign hrdata    = ((state == S_DATA) && !req.write) ? mem[req.idx] : '0;

  assign old_w = mem[req.idx];
  assign new_w = hwdata;

  for (genvar b = 0; b < NBYTES; b++) begin : g_lane
    ahb_smr_lane #(.LANE(b), .LANE_W(LANE_W)) u_lane (
      .start    (req.lane),
      .size     (req.size),
      .old_byte (old_w[b]),
      .new_byte (new_w[b]),
      .merged   (merged_w[b])
    );
  end

  // Write lands on the edge that closes DATA, ahead of any read pipelined behind it.
  always_ff @(posedge hclk) begin
    if ((state == S_DATA) && req.write) mem[req.idx] <= merged_w;
  end
endmodule

// File: tb/tb_ahb_slave_mem_responder.sv
// Scoreboard bench: two responders (zero-wait at base 0, two-wait at base 0x1000)
// share the request bus; the monitor checks every data phase against queued expectations.
module tb_ahb_slave_mem_responder;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SEQ = 2'b11;

  typedef struct {
    logic        err;
    logic        rd;
    logic [31:0] data;
    int          waits;
  } exp_t;

  logic        hclk = 1'b0, hresetn = 1'b0;
  logic        hsel = 1'b0, hwrite = 1'b0, sel = 1'b0;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [1:0]  htrans = T_IDLE;
  logic [2:0]  hsize = 3'd2, hburst = 3'd0;
  logic        ro0, rs0, ro1, rs1, ro, rs;
  logic [31:0] rd0, rd1, rd;

  logic [31:0] model [2][256];
  exp_t        sb [$];
  exp_t        me;
  bit          in_dp = 1'b0;
  int          wcnt = 0;
  int          checks = 0, errors = 0;

  always #5 hclk = ~hclk;

  assign ro = sel ? ro1 : ro0;
  assign rs = sel ? rs1 : rs0;
  assign rd = sel ? rd1 : rd0;

  ahb_slave_mem_responder u_dut0 (
    .hclk(hclk), .hresetn(hresetn), .hselx(hsel && !sel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(ro0),
    .hreadyout(ro0), .hresp(rs0), .hrdata(rd0)
  );

  ahb_slave_mem_responder #(.WAIT_STATES(2), .BASE_ADDR(32'h1000)) u_dut1 (
    .hclk(hclk), .hresetn(hresetn), .hselx(hsel && sel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(ro1),
    .hreadyout(ro1), .hresp(rs1), .hrdata(rd1)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic beat(input logic wr, input logic [1:0] tr, input logic [31:0] addr,
                      input logic [2:0] sz, input logic [31:0] wd);
    exp_t        e;
    logic [31:0] base, off;
    int          n, lane;
    base    = sel ? 32'h1000 : 32'h0;
    off     = addr - base;
    e.err   = (addr < base) || (off >= 32'h400) || (sz > 3'd2) ||
              ((addr & ((32'd1 << sz) - 32'd1)) != 32'd0);
    e.rd    = !wr;
    e.waits = e.err ? 1 : (sel ? 2 : 0);
    e.data  = '0;
    if (!e.err) begin
      if (wr) begin
        for (int b = 0; b < (1 << sz); b++) begin
          lane = int'(addr[1:0]) + b;
          model[sel][off[9:2]][lane*8 +: 8] = wd[lane*8 +: 8];
        end
      end else begin
        e.data = model[sel][off[9:2]];
      end
    end
    hsel = 1'b1; htrans = tr; haddr = addr; hwrite = wr; hsize = sz;
    sb.push_back(e);
    n = 0;
    @(negedge hclk);
    while (!ro && n < 50) begin
      n++;
      @(negedge hclk);
    end
    chk("accept_in_time", 32'(n < 50), 32'd1);
    @(posedge hclk); #1;
    hwdata = wd;
  endtask

  task automatic idle(input int n);
    hsel = 1'b0; htrans = T_IDLE; hwrite = 1'b0;
    repeat (n) @(posedge hclk);
    #1;
  endtask

  task automatic noxfer(input int n, input logic [1:0] tr);
    hsel = 1'b1; htrans = tr; haddr = '0; hwrite = 1'b1; hsize = 3'd2; hwdata = 32'hFFFF_FFFF;
    repeat (n) @(posedge hclk);
    #1;
    hsel = 1'b0; htrans = T_IDLE; hwrite = 1'b0;
  endtask

  // Monitor: sampled on the falling edge, where inputs and outputs are stable.
  always @(negedge hclk) begin
    if (!hresetn) begin
      in_dp = 1'b0;
      wcnt  = 0;
      sb.delete();
    end else begin
      if (in_dp) begin
        me = '{err: 1'b0, rd: 1'b0, data: 32'h0, waits: 0};
        if (sb.size() != 0) me = sb[0];
        chk("dphase_resp", 32'(rs), 32'(me.err));
        if (!ro) begin
          wcnt++;
          chk("wait_rdata_zero", rd, 32'h0);
        end else begin
          chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
          chk("wait_cycles", 32'(wcnt), 32'(me.waits));
          if (me.rd || me.err) chk("rdata", rd, me.err ? 32'h0 : me.data);
          if (sb.size() != 0) void'(sb.pop_front());
          in_dp = 1'b0;
          wcnt  = 0;
        end
      end else begin
        chk("idle_ready", 32'(ro), 32'd1);
        chk("idle_resp", 32'(rs), 32'd0);
        chk("idle_rdata", rd, 32'h0);
      end
      if (ro && hsel && htrans[1]) in_dp = 1'b1;
    end
  end

  initial begin
    repeat (3) @(posedge hclk);
    #1;
    chk("rst_ready0", 32'(ro0), 32'd1);
    chk("rst_resp0", 32'(rs0), 32'd0);
    chk("rst_rdata0", rd0, 32'h0);
    chk("rst_ready1", 32'(ro1), 32'd1);
    chk("rst_resp1", 32'(rs1), 32'd0);
    chk("rst_rdata1", rd1, 32'h0);
    hresetn = 1'b1;
    @(posedge hclk); #1;

    // zero-wait slave: back-to-back write/read, byte and halfword lanes
    beat(1'b1, T_NS, 32'h10, 3'd2, 32'hDEAD_BEEF);
    beat(1'b0, T_NS, 32'h10, 3'd2, 32'h0);
    idle(3);
    beat(1'b1, T_NS, 32'h10, 3'd2, 32'h1122_3344);
    beat(1'b1, T_NS, 32'h13, 3'd0, 32'hAA00_0000);
    beat(1'b0, T_NS, 32'h10, 3'd2, 32'h0);
    idle(3);
    beat(1'b1, T_NS, 32'h14, 3'd2, 32'h5566_7788);
    beat(1'b1, T_NS, 32'h16, 3'd1, 32'hBEEF_0000);
    beat(1'b0, T_NS, 32'h14, 3'd2, 32'h0);
    idle(3);

    // top of map, then one past it
    beat(1'b1, T_NS, 32'h3FC, 3'd2, 32'h0BAD_CAFE);
    beat(1'b0, T_NS, 32'h3FC, 3'd2, 32'h0);
    beat(1'b0, T_NS, 32'h400, 3'd2, 32'h0);
    idle(4);

    // misaligned write, oversized read, memory unchanged
    beat(1'b1, T_NS, 32'h0, 3'd2, 32'hA5A5_A5A5);
    beat(1'b1, T_NS, 32'h2, 3'd2, 32'h1234_5678);
    idle(4);
    beat(1'b0, T_NS, 32'h0, 3'd3, 32'h0);
    idle(4);
    beat(1'b0, T_NS, 32'h0, 3'd2, 32'h0);
    idle(2);

    // BUSY / IDLE while selected: zero-wait OKAY, no write
    noxfer(3, T_BUSY);
    noxfer(2, T_IDLE);
    beat(1'b0, T_NS, 32'h0, 3'd2, 32'h0);
    idle(2);

    // pipelined burst at one beat per cycle
    for (int i = 0; i < 4; i++)
      beat(1'b1, (i == 0) ? T_NS : T_SEQ, 32'h40 + 32'(4 * i), 3'd2, $urandom);
    for (int i = 0; i < 4; i++)
      beat(1'b0, (i == 0) ? T_NS : T_SEQ, 32'h40 + 32'(4 * i), 3'd2, 32'h0);
    idle(3);

    // two-wait slave at base 0x1000
    sel = 1'b1;
    beat(1'b1, T_NS, 32'h1004, 3'd2, 32'hCAFE_F00D);
    idle(5);
    beat(1'b0, T_NS, 32'h1004, 3'd2, 32'h0);
    idle(5);
    beat(1'b0, T_NS, 32'h0FFC, 3'd2, 32'h0);
    idle(4);
    beat(1'b1, T_NS, 32'h1020, 3'd2, 32'h1234_5678);
    idle(5);

    // reset in the middle of a waited write: aborts, write dropped
    hsel = 1'b1; htrans = T_NS; haddr = 32'h1020; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    hwdata = 32'h0000_0055; hsel = 1'b0; htrans = T_IDLE; hwrite = 1'b0;
    chk("in_wait_before_rst", 32'(ro1), 32'd0);
    #2 hresetn = 1'b0;
    #1;
    chk("midrst_ready", 32'(ro1), 32'd1);
    chk("midrst_resp", 32'(rs1), 32'd0);
    chk("midrst_rdata", rd1, 32'h0);
    #7 hresetn = 1'b1;
    @(posedge hclk); #1;
    beat(1'b0, T_NS, 32'h1020, 3'd2, 32'h0);
    idle(5);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
